// File: rtl/pwr_gate_ctrl_if.sv
// rtl/pwr_gate_ctrl_if.sv - power manager <-> power gate controller handshake and domain controls
interface pwr_gate_ctrl_if #(
  parameter int SEGS = 4
);
  logic            pwr_req;
  logic            pwr_ack;
  logic [SEGS-1:0] hdr_en_n;
  logic            iso;
  logic            dom_rst_n;
  logic            busy;

  // Power manager side: issues the request, observes the sequencer
  modport master (
    output pwr_req,
    input  pwr_ack, hdr_en_n, iso, dom_rst_n, busy
  );

  // Sequencer side
  modport slave (
    input  pwr_req,
    output pwr_ack, hdr_en_n, iso, dom_rst_n, busy
  );
endinterface

// File: rtl/pwr_gate_ctrl.sv
// rtl/pwr_gate_ctrl.sv - staggered header power-up / isolated power-down sequencer
module pwr_gate_ctrl #(
  parameter int SEGS        = 4,
  parameter int STAGGER_CYC = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int ISO_CYC     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  pwr_gate_ctrl_if.slave bus
);

  localparam int MAXC_A = (STAGGER_CYC > SETTLE_CYC) ? STAGGER_CYC : SETTLE_CYC;
  localparam int MAXC   = (MAXC_A > ISO_CYC) ? MAXC_A : ISO_CYC;
  localparam int CW     = $clog2(MAXC + 1);

  // Counters are loaded with N-1 so that the step fires on the Nth edge
  localparam logic [CW-1:0] C_STAG = CW'(STAGGER_CYC - 1);
  localparam logic [CW-1:0] C_SET  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] C_ISO  = CW'(ISO_CYC - 1);

  typedef enum logic [2:0] {
    S_OFF, S_WAKE, S_SETTLE, S_RELEASE, S_ON, S_ISO, S_DRST
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [SEGS-1:0] r_hdr_en_n;
  logic            r_iso;
  logic            r_dom_rst_n;
  logic            r_pwr_ack;
  logic            r_busy;

  // Segments turn on by shifting a zero in from bit 0, so they can only
  // clear in order 0..SEGS-1 and never re-set during wake-up.
  logic [SEGS-1:0] w_hdr_shift;
  logic            w_last;
  assign w_hdr_shift = r_hdr_en_n << 1;
  assign w_last      = (w_hdr_shift == '0);

  // Once the last segment conducts, the same counter times the settle window
  // starting from that edge, which is why WAKE may hand straight to RELEASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_OFF;
      r_cnt       <= '0;
      r_hdr_en_n  <= '1;
      r_iso       <= 1'b1;
      r_dom_rst_n <= 1'b0;
      r_pwr_ack   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          if (bus.pwr_req) begin
            r_state    <= S_WAKE;
            r_hdr_en_n <= w_hdr_shift;
            r_cnt      <= w_last ? C_SET : C_STAG;
            r_busy     <= 1'b1;
          end
        end
        S_WAKE: begin
          if (r_hdr_en_n == '0) begin
            if (r_cnt == '0) begin
              r_state     <= S_RELEASE;
              r_dom_rst_n <= 1'b1;
            end else begin
              r_state <= S_SETTLE;
              r_cnt   <= r_cnt - 1'b1;
            end
          end else if (r_cnt == '0) begin
            r_hdr_en_n <= w_hdr_shift;
            r_cnt      <= w_last ? C_SET : C_STAG;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_state     <= S_RELEASE;
            r_dom_rst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RELEASE: begin
          r_state   <= S_ON;
          r_iso     <= 1'b0;
          r_pwr_ack <= 1'b1;
          r_busy    <= 1'b0;
        end
        S_ON: begin
          if (!bus.pwr_req) begin
            r_state <= S_ISO;
            r_iso   <= 1'b1;
            r_cnt   <= C_ISO;
            r_busy  <= 1'b1;
          end
        end
        S_ISO: begin
          if (r_cnt == '0) begin
            r_state     <= S_DRST;
            r_dom_rst_n <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DRST: begin
          r_state    <= S_OFF;
          r_hdr_en_n <= '1;
          r_pwr_ack  <= 1'b0;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= S_OFF;
        end
      endcase
    end
  end

  assign bus.hdr_en_n  = r_hdr_en_n;
  assign bus.iso       = r_iso;
  assign bus.dom_rst_n = r_dom_rst_n;
  assign bus.pwr_ack   = r_pwr_ack;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_pwr_gate_ctrl.sv
// tb/tb_pwr_gate_ctrl.sv - directed bench for pwr_gate_ctrl (default and minimum parameter sets)
module tb_pwr_gate_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pwr_gate_ctrl_if #(.SEGS(4)) if_a ();
  pwr_gate_ctrl_if #(.SEGS(1)) if_b ();

  pwr_gate_ctrl #(.SEGS(4), .STAGGER_CYC(4), .SETTLE_CYC(8), .ISO_CYC(2)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  pwr_gate_ctrl #(.SEGS(1), .STAGGER_CYC(1), .SETTLE_CYC(1), .ISO_CYC(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop if the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // Packed observations: {hdr_en_n, iso, dom_rst_n, pwr_ack, busy}
  function automatic logic [7:0] obs_a();
    return {if_a.hdr_en_n, if_a.iso, if_a.dom_rst_n, if_a.pwr_ack, if_a.busy};
  endfunction
  function automatic logic [4:0] obs_b();
    return {if_b.hdr_en_n, if_b.iso, if_b.dom_rst_n, if_b.pwr_ack, if_b.busy};
  endfunction

  // Defaults, t edges after E0 of power-up: segment k on at 4k, release at 20, ack at 21
  function automatic logic [7:0] up_a(input int t);
    logic [3:0] h;
    int         n;
    n = t / 4 + 1;
    if (n > 4) n = 4;
    h = 4'hF;
    h = h << n;
    return {h, (t < 21), (t >= 20), (t >= 21), (t < 21)};
  endfunction
  // Defaults, t edges after E0 of power-down: reset at 2, headers off and ack low at 3
  function automatic logic [7:0] down_a(input int t);
    return {((t >= 3) ? 4'hF : 4'h0), 1'b1, (t < 2), (t < 3), (t < 3)};
  endfunction
  // All-ones parameters: release at 1, ack at 2
  function automatic logic [4:0] up_b(input int t);
    return {1'b0, (t < 2), (t >= 1), (t >= 2), (t < 2)};
  endfunction
  function automatic logic [4:0] down_b(input int t);
    return {(t >= 2), 1'b1, (t < 1), (t < 2), (t < 2)};
  endfunction

  localparam logic [7:0] RST_A = 8'b1111_1_0_0_0;
  localparam logic [4:0] RST_B = 5'b1_1_0_0_0;

  task automatic test_reset();
    rst_n        = 1'b0;
    if_a.pwr_req = 1'b0;
    if_b.pwr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs_a() !== RST_A) begin
        n_err++;
        $display("FAIL reset_a cycle %0d: got %b required %b", c, obs_a(), RST_A);
      end
      n_vec++;
      if (obs_b() !== RST_B) begin
        n_err++;
        $display("FAIL reset_b cycle %0d: got %b required %b", c, obs_b(), RST_B);
      end
    end
  endtask

  task automatic test_power_up();
    if_a.pwr_req = 1'b1;
    for (int t = 0; t <= 25; t++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs_a() !== up_a(t)) begin
        n_err++;
        $display("FAIL power_up E0+%0d: got %b required %b", t, obs_a(), up_a(t));
      end
    end
  endtask

  task automatic test_power_down();
    if_a.pwr_req = 1'b0;
    for (int t = 0; t <= 5; t++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs_a() !== down_a(t)) begin
        n_err++;
        $display("FAIL power_down E0+%0d: got %b required %b", t, obs_a(), down_a(t));
      end
    end
  endtask

  task automatic test_glitch();
    if_a.pwr_req = 1'b1;
    for (int t = 0; t <= 21; t++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs_a() !== up_a(t)) begin
        n_err++;
        $display("FAIL glitch_up E0+%0d: got %b required %b", t, obs_a(), up_a(t));
      end
      if (t == 4) if_a.pwr_req = 1'b0;
    end
    for (int t = 0; t <= 4; t++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs_a() !== down_a(t)) begin
        n_err++;
        $display("FAIL glitch_down E0+%0d: got %b required %b", t, obs_a(), down_a(t));
      end
    end
  endtask

  task automatic test_reset_mid();
    if_a.pwr_req = 1'b1;
    for (int t = 0; t <= 10; t++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs_a() !== up_a(t)) begin
        n_err++;
        $display("FAIL pre_reset E0+%0d: got %b required %b", t, obs_a(), up_a(t));
      end
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs_a() !== RST_A) begin
      n_err++;
      $display("FAIL async_reset: got %b required %b", obs_a(), RST_A);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t <= 22; t++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs_a() !== up_a(t)) begin
        n_err++;
        $display("FAIL post_reset E0+%0d: got %b required %b", t, obs_a(), up_a(t));
      end
    end
  endtask

  task automatic test_min_params();
    if_b.pwr_req = 1'b1;
    for (int t = 0; t <= 3; t++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs_b() !== up_b(t)) begin
        n_err++;
        $display("FAIL min_up E0+%0d: got %b required %b", t, obs_b(), up_b(t));
      end
    end
    if_b.pwr_req = 1'b0;
    for (int t = 0; t <= 3; t++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs_b() !== down_b(t)) begin
        n_err++;
        $display("FAIL min_down E0+%0d: got %b required %b", t, obs_b(), down_b(t));
      end
    end
  endtask

  // Structural invariants, sampled on the falling edge
  logic [3:0] p_hdr_a;
  logic       p_ack_a, p_busy_a, p_ack_b, p_busy_b;
  logic [3:0] w_nh;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && !$isunknown(obs_a()) && !$isunknown(obs_b())) begin
      n_vec++;
      if ((|if_a.hdr_en_n && !if_a.iso) || (if_b.hdr_en_n[0] && !if_b.iso)) begin
        n_err++;
        $display("FAIL inv_iso: a=%b b=%b required iso=1 while a header is off", obs_a(), obs_b());
      end
      n_vec++;
      if ((if_a.dom_rst_n && if_a.hdr_en_n != 4'h0) || (if_b.dom_rst_n && if_b.hdr_en_n != 1'b0)) begin
        n_err++;
        $display("FAIL inv_drst: a=%b b=%b required dom_rst_n=0 unless all headers on", obs_a(), obs_b());
      end
      w_nh = ~if_a.hdr_en_n;
      n_vec++;
      if (if_a.hdr_en_n != 4'hF && (((if_a.hdr_en_n & ~p_hdr_a) != 4'h0) || ((w_nh & (w_nh + 4'h1)) != 4'h0))) begin
        n_err++;
        $display("FAIL inv_order: hdr %b after %b required in-order clearing", if_a.hdr_en_n, p_hdr_a);
      end
      n_vec++;
      if ((if_a.pwr_ack != p_ack_a && !(p_busy_a && !if_a.busy)) ||
          (if_b.pwr_ack != p_ack_b && !(p_busy_b && !if_b.busy))) begin
        n_err++;
        $display("FAIL inv_ack: a=%b b=%b required ack change only on OFF/ON entry", obs_a(), obs_b());
      end
    end
    p_hdr_a  <= if_a.hdr_en_n;
    p_ack_a  <= if_a.pwr_ack;
    p_busy_a <= if_a.busy;
    p_ack_b  <= if_b.pwr_ack;
    p_busy_b <= if_b.busy;
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_power_up();
    test_power_down();
    test_glitch();
    test_reset_mid();
    test_min_params();
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
